// File: rtl/missile_fire_ctrl.sv
// Fire-control stage: debounces the fire key into fixed-length fire pulses, allows one missile
// in flight, enforces a post-flight cooldown and regenerates ammunition once per reload period.
module missile_fire_ctrl #(
  parameter int unsigned MAX_AMMO              = 9,
  parameter int unsigned COOLDOWN_FRAMES       = 15,
  parameter int unsigned RELOAD_FRAMES         = 60,
  parameter int unsigned FLIGHT_TIMEOUT_FRAMES = 60,
  parameter int unsigned FIRE_PULSE_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       fireKey,
  input  logic       missileDone,
  output logic       fire,
  output logic [3:0] ammo,
  output logic       ready
);

  localparam logic [3:0] AmmoMax       = 4'(MAX_AMMO);
  localparam logic [7:0] CooldownLoad  = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] ReloadLast    = 8'(RELOAD_FRAMES - 1);
  localparam logic [7:0] FlightTimeout = 8'(FLIGHT_TIMEOUT_FRAMES);
  localparam logic [3:0] PulseLast     = 4'(FIRE_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {StReady, StFiring, StFlight, StCooldown} state_e;

  state_e     state_q, state_d;
  logic       fire_q, fire_d;
  logic [3:0] ammo_q, ammo_d;
  logic       key_q;
  logic [3:0] pulse_cnt_q, pulse_cnt_d;
  logic [7:0] flight_cnt_q, flight_cnt_d;
  logic [7:0] cd_cnt_q, cd_cnt_d;
  logic [7:0] reload_cnt_q, reload_cnt_d;
  logic       done_pending_q, done_pending_d;

  logic key_edge;
  logic shot;
  logic regen;

  assign key_edge = fireKey & ~key_q;

  always_comb begin
    state_d        = state_q;
    fire_d         = 1'b0;
    pulse_cnt_d    = pulse_cnt_q;
    flight_cnt_d   = flight_cnt_q;
    cd_cnt_d       = cd_cnt_q;
    done_pending_d = done_pending_q;
    shot           = 1'b0;
    unique case (state_q)
      StReady: begin
        // Edges while not ready fall through here and are simply lost.
        if (key_edge && (ammo_q != 4'd0)) begin
          shot        = 1'b1;
          state_d     = StFiring;
          pulse_cnt_d = PulseLast;
          fire_d      = 1'b1;
        end
      end
      StFiring: begin
        if (missileDone) done_pending_d = 1'b1;
        if (pulse_cnt_q == 4'd0) begin
          state_d      = StFlight;
          flight_cnt_d = 8'd0;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 4'd1;
          fire_d      = 1'b1;
        end
      end
      StFlight: begin
        if (missileDone || done_pending_q || (flight_cnt_q == FlightTimeout)) begin
          state_d        = StCooldown;
          cd_cnt_d       = CooldownLoad;
          done_pending_d = 1'b0;
        end else if (startOfFrame && (flight_cnt_q != 8'hFF)) begin
          flight_cnt_d = flight_cnt_q + 8'd1;
        end
      end
      StCooldown: begin
        if (cd_cnt_q == 8'd0) begin
          state_d = StReady;
        end else if (startOfFrame) begin
          cd_cnt_d = cd_cnt_q - 8'd1;
        end
      end
      default: state_d = StReady;
    endcase
  end

  always_comb begin
    reload_cnt_d = reload_cnt_q;
    regen        = 1'b0;
    if (ammo_q >= AmmoMax) begin
      reload_cnt_d = 8'd0;
    end else if (startOfFrame) begin
      if (reload_cnt_q >= ReloadLast) begin
        regen        = 1'b1;
        reload_cnt_d = 8'd0;
      end else begin
        reload_cnt_d = reload_cnt_q + 8'd1;
      end
    end
  end

  // A shot needs ammo_q != 0 and a regen needs ammo_q < max, so neither path can overflow.
  always_comb begin
    ammo_d = ammo_q;
    unique case ({shot, regen})
      2'b10:   ammo_d = ammo_q - 4'd1;
      2'b01:   ammo_d = ammo_q + 4'd1;
      default: ammo_d = ammo_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= StReady;
      fire_q         <= 1'b0;
      ammo_q         <= AmmoMax;
      key_q          <= 1'b0;
      pulse_cnt_q    <= 4'd0;
      flight_cnt_q   <= 8'd0;
      cd_cnt_q       <= 8'd0;
      reload_cnt_q   <= 8'd0;
      done_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fire_q         <= fire_d;
      ammo_q         <= ammo_d;
      key_q          <= fireKey;
      pulse_cnt_q    <= pulse_cnt_d;
      flight_cnt_q   <= flight_cnt_d;
      cd_cnt_q       <= cd_cnt_d;
      reload_cnt_q   <= reload_cnt_d;
      done_pending_q <= done_pending_d;
    end
  end

  assign fire  = fire_q;
  assign ammo  = ammo_q;
  assign ready = (state_q == StReady) && (ammo_q != 4'd0);

endmodule
